// File: rtl/fetch_sequencer.sv
// fetch_sequencer: start/abort/halt-controlled instruction fetch with valid/ready issue; `FETCH_STEP_EN adds step_mode_i/step_i single-stepping.
module fetch_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  start_addr_i,
    input  logic               abort_i,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic [INSTR_W-1:0] mem_instr_i,
    output logic               issue_valid_o,
    input  logic               issue_ready_i,
    output logic [INSTR_W-1:0] issue_instr_o,
    output logic [ADDR_W-1:0]  issue_pc_o,
`ifdef FETCH_STEP_EN
    input  logic               step_mode_i,
    input  logic               step_i,
`endif
    output logic               running_o,
    output logic               halted_o
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;
    localparam logic [3:0] OP_NOP = 4'hF, OP_JMP = 4'hE, OP_HALT = 4'hD;
    state_t state_q;
    logic [ADDR_W-1:0] pc_q, issue_pc_q;
    logic [INSTR_W-1:0] issue_instr_q;
    logic issue_valid_q, running_q, halted_q;
    logic [3:0] op;
    logic step_ok, dec;
    assign op = mem_instr_i[INSTR_W-1 -: 4];
`ifdef FETCH_STEP_EN
    assign step_ok = !step_mode_i || step_i;
`else
    assign step_ok = 1'b1;
`endif
    assign dec = step_ok && (state_q == FETCH || (state_q == ISSUE && issue_ready_i));
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            issue_valid_q <= 1'b0;
            issue_instr_q <= '0;
            issue_pc_q    <= '0;
            running_q     <= 1'b0;
            halted_q      <= 1'b0;
        end else if (abort_i && state_q != IDLE) begin
            state_q       <= IDLE;
            issue_valid_q <= 1'b0;
            running_q     <= 1'b0;
            halted_q      <= 1'b0;
        end else if (start_i && !abort_i && (state_q == IDLE || state_q == HALTED)) begin
            state_q   <= FETCH;
            pc_q      <= start_addr_i;
            running_q <= 1'b1;
            halted_q  <= 1'b0;
        end else if (dec) begin
            issue_valid_q <= 1'b0;
            state_q       <= FETCH;
            running_q     <= 1'b1;
            halted_q      <= 1'b0;
            if (op == OP_NOP) begin
                pc_q <= pc_q + 1'b1;
            end else if (op == OP_JMP) begin
                pc_q <= mem_instr_i[ADDR_W-1:0];
            end else if (op == OP_HALT) begin
                state_q   <= HALTED;
                running_q <= 1'b0;
                halted_q  <= 1'b1;
            end else begin
                issue_instr_q <= mem_instr_i;
                issue_pc_q    <= pc_q;
                issue_valid_q <= 1'b1;
                pc_q          <= pc_q + 1'b1;
                state_q       <= ISSUE;
            end
        end else if (state_q == ISSUE && issue_ready_i) begin
            // consumed while waiting for a step: fall back to FETCH, pc already points past it
            issue_valid_q <= 1'b0;
            state_q       <= FETCH;
        end
    end
    assign mem_addr_o    = pc_q;
    assign issue_valid_o = issue_valid_q;
    assign issue_instr_o = issue_instr_q;
    assign issue_pc_o    = issue_pc_q;
    assign running_o     = running_q;
    assign halted_o      = halted_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer driving a behavioural instruction memory.
module tb_fetch_sequencer;
    localparam int ADDR_W = 8, INSTR_W = 16;
    logic clk, rst, start, abort, issue_ready, issue_valid, running, halted;
    logic [ADDR_W-1:0] start_addr, mem_addr, issue_pc;
    logic [INSTR_W-1:0] mem_instr, issue_instr;
    logic [INSTR_W-1:0] mem [256];
    logic [INSTR_W+ADDR_W-1:0] exp_q [$];
    logic [INSTR_W+ADDR_W-1:0] e;
    int n_checks = 0, n_fail = 0;
`ifdef FETCH_STEP_EN
    logic step_mode, step;
`endif
    fetch_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk(clk), .rst(rst), .start_i(start), .start_addr_i(start_addr), .abort_i(abort),
        .mem_addr_o(mem_addr), .mem_instr_i(mem_instr), .issue_valid_o(issue_valid),
        .issue_ready_i(issue_ready), .issue_instr_o(issue_instr), .issue_pc_o(issue_pc),
`ifdef FETCH_STEP_EN
        .step_mode_i(step_mode), .step_i(step),
`endif
        .running_o(running), .halted_o(halted)
    );
    assign mem_instr = mem[mem_addr];
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst && issue_valid && issue_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_instr", 32'(issue_instr), 32'(e[ADDR_W +: INSTR_W]));
                check("sb_pc", 32'(issue_pc), 32'(e[ADDR_W-1:0]));
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [INSTR_W-1:0] i, input logic [ADDR_W-1:0] p);
        exp_q.push_back({i, p});
    endtask
    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hD000;
    endtask
    task automatic load_prog1();
        clear_mem();
        mem[0] = 16'hF000; mem[1] = 16'h0102; mem[2] = 16'h0103; mem[3] = 16'hF000;
        mem[4] = 16'h1510; mem[5] = 16'hF000; mem[6] = 16'h5510; mem[7] = 16'hD000;
    endtask
    task automatic push_prog1();
        push(16'h0102, 1); push(16'h0103, 2); push(16'h1510, 4); push(16'h5510, 6);
    endtask
    task automatic do_reset();
        rst = 1; start = 0; abort = 0;
        tick(); tick();
        rst = 0;
    endtask
    task automatic do_start(input logic [ADDR_W-1:0] a);
        start = 1; start_addr = a;
        tick();
        start = 0;
    endtask
    task automatic wait_halt(input string tag);
        int c = 0;
        while (!halted && c < 40) begin tick(); c++; end
        check(tag, 32'(halted), 1);
    endtask
    initial begin
        int cyc, bad;
        bit saw2;
        rst = 1; start = 0; abort = 0; issue_ready = 1; start_addr = 0;
`ifdef FETCH_STEP_EN
        step_mode = 0; step = 0;
`endif
        load_prog1();
        do_reset();
        check("rst_valid", 32'(issue_valid), 0);
        check("rst_instr", 32'(issue_instr), 0);
        check("rst_pc", 32'(issue_pc), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_running", 32'(running), 0);
        check("rst_halted", 32'(halted), 0);
        // straight-line program with NOPs, always ready
        push_prog1();
        do_start(0);
        cyc = 1;
        while (!issue_valid && cyc < 20) begin tick(); cyc++; end
        check("t1_latency", cyc, 3);
        wait_halt("t1_halted");
        check("t1_halt_addr", 32'(mem_addr), 7);
        check("t1_not_running", 32'(running), 0);
        check("t1_drain", exp_q.size(), 0);
        // backpressure
        do_reset();
        issue_ready = 0;
        push_prog1();
        do_start(0);
        cyc = 0;
        while (!issue_valid && cyc < 20) begin tick(); cyc++; end
        check("t2_valid", 32'(issue_valid), 1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (issue_instr !== 16'h0102 || issue_pc !== 1 || mem_addr !== 2 || !issue_valid) bad++;
            if (i < 4) tick();
        end
        check("t2_stable", bad, 0);
        check("t2_hold_addr", 32'(mem_addr), 2);
        issue_ready = 1;
        tick();
        check("t2_next_valid", 32'(issue_valid), 1);
        check("t2_next_instr", 32'(issue_instr), 'h0103);
        wait_halt("t2_halted");
        check("t2_drain", exp_q.size(), 0);
        // forward jump skips address 2
        do_reset();
        clear_mem();
        mem[0] = 16'h0102; mem[1] = 16'hE005; mem[5] = 16'h5510; mem[6] = 16'hD000;
        push(16'h0102, 0); push(16'h5510, 5);
        do_start(0);
        saw2 = 0; cyc = 0;
        while (!halted && cyc < 30) begin
            if (mem_addr == 2) saw2 = 1;
            tick(); cyc++;
        end
        check("t3_halted", 32'(halted), 1);
        check("t3_no_addr2", 32'(saw2), 0);
        check("t3_drain", exp_q.size(), 0);
        // self-jump, abort, start+abort in IDLE
        do_reset();
        clear_mem();
        mem[0] = 16'hE000;
        do_start(0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!running || issue_valid) bad++;
            tick();
        end
        check("t4_loop", bad, 0);
        abort = 1;
        tick();
        abort = 0;
        check("t4_abort_running", 32'(running), 0);
        check("t4_abort_valid", 32'(issue_valid), 0);
        check("t4_abort_halted", 32'(halted), 0);
        check("t4_abort_pc", 32'(mem_addr), 0);
        start = 1; abort = 1; start_addr = 9;
        tick();
        start = 0; abort = 0;
        tick();
        check("t4_sa_running", 32'(running), 0);
        check("t4_sa_addr", 32'(mem_addr), 0);
        // PC wrap-around, then reset during a pending issue
        do_reset();
        clear_mem();
        mem[255] = 16'h0102; mem[0] = 16'hD000;
        push(16'h0102, 255);
        do_start(255);
        wait_halt("t5_halted");
        check("t5_wrap_addr", 32'(mem_addr), 0);
        check("t5_drain", exp_q.size(), 0);
        issue_ready = 0;
        do_start(255);
        cyc = 0;
        while (!issue_valid && cyc < 20) begin tick(); cyc++; end
        check("t5_pending", 32'(issue_valid), 1);
        rst = 1;
        tick();
        rst = 0;
        check("t5_rst_valid", 32'(issue_valid), 0);
        check("t5_rst_instr", 32'(issue_instr), 0);
        check("t5_rst_pc", 32'(issue_pc), 0);
        check("t5_rst_addr", 32'(mem_addr), 0);
        check("t5_rst_running", 32'(running), 0);
        check("t5_rst_halted", 32'(halted), 0);
        issue_ready = 1;
`ifdef FETCH_STEP_EN
        // single-step: one decode per step pulse
        do_reset();
        load_prog1();
        push_prog1();
        step_mode = 1;
        do_start(0);
        cyc = 0;
        while (!halted && cyc < 20) begin
            tick(); tick(); tick();
            if (cyc == 1) check("t6_no_valid_before", 32'(issue_valid), 0);
            step = 1;
            tick();
            step = 0;
            cyc++;
            if (cyc == 1) check("t6_pulse1_addr", 32'(mem_addr), 1);
            if (cyc == 2) check("t6_pulse2_valid", 32'(issue_valid), 1);
        end
        check("t6_pulses", cyc, 8);
        check("t6_drain", exp_q.size(), 0);
        step_mode = 0;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller sitting between the program counter/instruction memory pair and the execute stage. It owns the PC and drives the address of the combinational-read instruction memory. It retires NOP, JMP and HALT internally and presents every other instruction to the execute stage over a valid/ready handshake. It replaces the free-running `next`-driven counter with a start/abort/halt-controlled sequencer.

Parameters:
ADDR_W, 8, PC and memory address width; PC wraps modulo 2^ADDR_W.
INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1:INSTR_W-4].

Ports:
clk  in  1  rising-edge clock, single clock domain.
rst  in  1  synchronous, active-high reset.
start  in  1  begin fetching at start_addr; honoured only in IDLE or HALTED.
start_addr  in  ADDR_W  initial PC for start.
abort  in  1  return to IDLE from any state; has priority over start.
mem_addr  out  ADDR_W  instruction memory address; always equals the pc register.
mem_instr  in  INSTR_W  instruction memory data, valid in the same cycle as mem_addr.
issue_valid  out  1  issue_instr and issue_pc hold an instruction for execute.
issue_ready  in  1  execute accepts the instruction this cycle.
issue_instr  out  INSTR_W  issued instruction.
issue_pc  out  ADDR_W  address the issued instruction was fetched from.
running  out  1  high in FETCH or ISSUE.
halted  out  1  high in HALTED.

Behaviour:
- Reset: state=IDLE, pc=0, issue_valid=0, issue_instr=0, issue_pc=0, running=0, halted=0. rst overrides every other input, including mid-issue.
- Opcodes: 4'hF NOP, 4'hE JMP (target = instr[ADDR_W-1:0]), 4'hD HALT. Every other opcode is issuable (LOAD 0x0, MOV 0x1, ADD 0x5, ...).
- State IDLE:
  - start=1 & abort=0: pc<=start_addr, go to FETCH.
  - Otherwise hold all outputs.
- Decode step. Performed in FETCH, and in ISSUE on the cycle a handshake completes. Acts on mem_instr at the current pc:
  - NOP: pc<=pc+1, issue_valid<=0, go to/stay in FETCH.
  - JMP: pc<=target, issue_valid<=0, go to FETCH.
  - HALT: pc unchanged (points at the HALT), issue_valid<=0, go to HALTED.
  - Other: issue_instr<=mem_instr, issue_pc<=pc, issue_valid<=1, pc<=pc+1, go to ISSUE.
- State ISSUE:
  - issue_valid=1 & issue_ready=0: issue_instr, issue_pc and pc hold stable. No fetch decode.
  - issue_ready=1: the instruction is consumed and the decode step runs the same cycle. This gives back-to-back issue of 1 instruction/cycle with no bubbles, except that NOP/JMP/HALT each cost one bubble.
- State HALTED:
  - halted=1, issue_valid=0.
  - start (abort=0) reloads pc from start_addr and goes to FETCH.
- Latency:
  - start sampled in cycle N: FETCH in N+1; an issuable instruction at start_addr gives issue_valid=1 in N+2.
  - Each leading NOP/JMP adds 1 cycle.
- abort (non-IDLE state): go to IDLE next cycle, issue_valid<=0, pc holds its value. An instruction pending in ISSUE is dropped even if issue_ready=1 in that cycle. Abort in IDLE has no effect.
- start while in FETCH or ISSUE: ignored.
- Wrap-around: pc=2^ADDR_W-1 followed by increment gives 0. No error is flagged.
- A JMP to its own address loops in FETCH forever with running=1 and no issue; only abort or rst exits.
- Outputs are registered, except mem_addr, which is a direct copy of the pc register.

Optional Feature:
FETCH_STEP_EN.
- Defined: adds input ports step_mode (1) and step (1). While step_mode=1, the decode step in FETCH/ISSUE runs only in cycles where step=1. Otherwise the block stalls with pc and issue_* held. A handshake still clears issue_valid without a step. NOP/JMP/HALT each consume one step. With step_mode=0, behaviour is identical to the undefined build.
- Undefined: the ports are absent and the decode step runs every eligible cycle.

Test Plan:
- Memory 0:F000, 1:0102, 2:0103, 3:F000, 4:1510, 5:F000, 6:5510, 7:D000; rst then start with start_addr=0 and issue_ready=1 -> issue sequence (0x0102,pc1), (0x0103,pc2), (0x1510,pc4), (0x5510,pc6); first issue_valid 3 cycles after start; then halted=1 with mem_addr=7.
- Same program, issue_ready=0 for 5 cycles after the first valid -> issue_instr=0x0102 and issue_pc=1 stable all 5 cycles, mem_addr=2; the next issue is 0x0103 the cycle after ready rises.
- Memory 0:0102, 1:E005, 5:5510, 6:D000 -> issues 0x0102 then 0x5510 (issue_pc=5); address 2 is never presented on mem_addr.
- Memory 0:E000 (self-jump); start; after 20 cycles assert abort -> running=1 and issue_valid=0 throughout; state=IDLE and running=0 the cycle after abort; start+abort asserted together in IDLE -> stays IDLE.
- start_addr=255 with 255:0102, 0:D000 -> issue (0x0102, pc255), then halted with mem_addr=0; rst asserted while issue_valid=1 -> all outputs at reset values next cycle.
- FETCH_STEP_EN: step_mode=1 with step pulses every 4 cycles on the first program -> exactly one decode per pulse; 0x0102 is issued after the second pulse.
